// File: rtl/axi_lite_reg_slice_pkg.sv
// Shared types for the AXI4-Lite register slice: per-channel slice modes and
// the AXI-Lite protection/response encodings carried through the slice.
package axi_lite_reg_slice_pkg;

   typedef enum logic [1:0] {
      SLICE_BYPASS = 2'd0,
      SLICE_HALF   = 2'd1,
      SLICE_FULL   = 2'd2
   } slice_mode_e;

   typedef logic [2:0] prot_t;
   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_slice_chan.sv
// Generic valid/ready/payload slice for one channel: bypass wire, 1-entry
// half-rate register, or 2-entry skid buffer selected at elaboration.
module axi_lite_slice_chan
   import axi_lite_reg_slice_pkg::*;
#(
   parameter int          WIDTH = 8,
   parameter slice_mode_e MODE  = SLICE_FULL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_src_valid,
   output logic             o_src_ready,
   input  logic [WIDTH-1:0] i_src_data,
   output logic             o_dst_valid,
   input  logic             i_dst_ready,
   output logic [WIDTH-1:0] o_dst_data,
   output logic             o_idle
);

   generate
      if (MODE == SLICE_BYPASS) begin : gen_bypass
         logic w_unused_clk_rst;
         assign w_unused_clk_rst = clk ^ rst;
         assign o_dst_valid      = i_src_valid;
         assign o_dst_data       = i_src_data;
         assign o_src_ready      = i_dst_ready;
         assign o_idle           = 1'b1;
      end else if (MODE == SLICE_HALF) begin : gen_half
         logic             r_valid;
         logic [WIDTH-1:0] r_data;

         assign o_src_ready = !r_valid;
         assign o_dst_valid = r_valid;
         assign o_dst_data  = r_data;
         assign o_idle      = !r_valid;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_valid <= 1'b0;
            end else if (r_valid) begin
               if (i_dst_ready) r_valid <= 1'b0;
            end else if (i_src_valid) begin
               r_valid <= 1'b1;
            end
         end

         // Payload flops carry no reset; they are only observed behind r_valid.
         always_ff @(posedge clk) begin
            if (!r_valid && i_src_valid) r_data <= i_src_data;
         end
      end else begin : gen_full
         logic             r_m_valid;
         logic             r_k_valid;
         logic [WIDTH-1:0] r_m_data;
         logic [WIDTH-1:0] r_k_data;
         logic             w_accept;
         logic             w_drain;

         assign o_src_ready = !r_k_valid;
         assign o_dst_valid = r_m_valid;
         assign o_dst_data  = r_m_data;
         assign o_idle      = !r_m_valid && !r_k_valid;
         assign w_accept    = i_src_valid && !r_k_valid;
         assign w_drain     = r_m_valid && i_dst_ready;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_m_valid <= 1'b0;
               r_k_valid <= 1'b0;
            end else if (w_drain) begin
               // A full skid blocks accept, so k refilling m never races a new beat.
               if (r_k_valid) begin
                  r_m_valid <= 1'b1;
                  r_k_valid <= 1'b0;
               end else begin
                  r_m_valid <= w_accept;
               end
            end else if (w_accept) begin
               if (r_m_valid) r_k_valid <= 1'b1;
               else           r_m_valid <= 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (w_drain) begin
               if (r_k_valid)     r_m_data <= r_k_data;
               else if (w_accept) r_m_data <= i_src_data;
            end else if (w_accept) begin
               if (r_m_valid) r_k_data <= i_src_data;
               else           r_m_data <= i_src_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/axi_lite_reg_slice.sv
// AXI4-Lite register slice: five independent channel slices between an
// upstream master (s_axi side) and a downstream slave (m_axi side).
module axi_lite_reg_slice
   import axi_lite_reg_slice_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter slice_mode_e AW_MODE    = SLICE_FULL,
   parameter slice_mode_e W_MODE     = SLICE_FULL,
   parameter slice_mode_e B_MODE     = SLICE_FULL,
   parameter slice_mode_e AR_MODE    = SLICE_FULL,
   parameter slice_mode_e R_MODE     = SLICE_FULL,
   localparam int         STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // upstream (faces the master)
   input  logic                  i_s_axi_awvalid,
   output logic                  o_s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] i_s_axi_awaddr,
   input  logic [2:0]            i_s_axi_awprot,
   input  logic                  i_s_axi_wvalid,
   output logic                  o_s_axi_wready,
   input  logic [DATA_WIDTH-1:0] i_s_axi_wdata,
   input  logic [STRB_WIDTH-1:0] i_s_axi_wstrb,
   output logic                  o_s_axi_bvalid,
   input  logic                  i_s_axi_bready,
   output logic [1:0]            o_s_axi_bresp,
   input  logic                  i_s_axi_arvalid,
   output logic                  o_s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] i_s_axi_araddr,
   input  logic [2:0]            i_s_axi_arprot,
   output logic                  o_s_axi_rvalid,
   input  logic                  i_s_axi_rready,
   output logic [DATA_WIDTH-1:0] o_s_axi_rdata,
   output logic [1:0]            o_s_axi_rresp,
   // downstream (faces the slave)
   output logic                  o_m_axi_awvalid,
   input  logic                  i_m_axi_awready,
   output logic [ADDR_WIDTH-1:0] o_m_axi_awaddr,
   output logic [2:0]            o_m_axi_awprot,
   output logic                  o_m_axi_wvalid,
   input  logic                  i_m_axi_wready,
   output logic [DATA_WIDTH-1:0] o_m_axi_wdata,
   output logic [STRB_WIDTH-1:0] o_m_axi_wstrb,
   input  logic                  i_m_axi_bvalid,
   output logic                  o_m_axi_bready,
   input  logic [1:0]            i_m_axi_bresp,
   output logic                  o_m_axi_arvalid,
   input  logic                  i_m_axi_arready,
   output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
   output logic [2:0]            o_m_axi_arprot,
   input  logic                  i_m_axi_rvalid,
   output logic                  o_m_axi_rready,
   input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
   input  logic [1:0]            i_m_axi_rresp,
   output logic                  idle
);

   localparam int AX_W = ADDR_WIDTH + 3;
   localparam int W_W  = DATA_WIDTH + STRB_WIDTH;
   localparam int B_W  = 2;
   localparam int R_W  = DATA_WIDTH + 2;

   logic [AX_W-1:0] w_aw_dst;
   logic [AX_W-1:0] w_ar_dst;
   logic [W_W-1:0]  w_w_dst;
   logic [B_W-1:0]  w_b_dst;
   logic [R_W-1:0]  w_r_dst;
   logic [4:0]      w_idle;

   axi_lite_slice_chan #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
      .clk         (clk),
      .rst         (rst),
      .i_src_valid (i_s_axi_awvalid),
      .o_src_ready (o_s_axi_awready),
      .i_src_data  ({i_s_axi_awaddr, i_s_axi_awprot}),
      .o_dst_valid (o_m_axi_awvalid),
      .i_dst_ready (i_m_axi_awready),
      .o_dst_data  (w_aw_dst),
      .o_idle      (w_idle[0])
   );

   axi_lite_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
      .clk         (clk),
      .rst         (rst),
      .i_src_valid (i_s_axi_wvalid),
      .o_src_ready (o_s_axi_wready),
      .i_src_data  ({i_s_axi_wdata, i_s_axi_wstrb}),
      .o_dst_valid (o_m_axi_wvalid),
      .i_dst_ready (i_m_axi_wready),
      .o_dst_data  (w_w_dst),
      .o_idle      (w_idle[1])
   );

   axi_lite_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
      .clk         (clk),
      .rst         (rst),
      .i_src_valid (i_m_axi_bvalid),
      .o_src_ready (o_m_axi_bready),
      .i_src_data  (i_m_axi_bresp),
      .o_dst_valid (o_s_axi_bvalid),
      .i_dst_ready (i_s_axi_bready),
      .o_dst_data  (w_b_dst),
      .o_idle      (w_idle[2])
   );

   axi_lite_slice_chan #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
      .clk         (clk),
      .rst         (rst),
      .i_src_valid (i_s_axi_arvalid),
      .o_src_ready (o_s_axi_arready),
      .i_src_data  ({i_s_axi_araddr, i_s_axi_arprot}),
      .o_dst_valid (o_m_axi_arvalid),
      .i_dst_ready (i_m_axi_arready),
      .o_dst_data  (w_ar_dst),
      .o_idle      (w_idle[3])
   );

   axi_lite_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
      .clk         (clk),
      .rst         (rst),
      .i_src_valid (i_m_axi_rvalid),
      .o_src_ready (o_m_axi_rready),
      .i_src_data  ({i_m_axi_rdata, i_m_axi_rresp}),
      .o_dst_valid (o_s_axi_rvalid),
      .i_dst_ready (i_s_axi_rready),
      .o_dst_data  (w_r_dst),
      .o_idle      (w_idle[4])
   );

   assign {o_m_axi_awaddr, o_m_axi_awprot} = w_aw_dst;
   assign {o_m_axi_araddr, o_m_axi_arprot} = w_ar_dst;
   assign {o_m_axi_wdata, o_m_axi_wstrb}   = w_w_dst;
   assign o_s_axi_bresp                    = w_b_dst;
   assign {o_s_axi_rdata, o_s_axi_rresp}   = w_r_dst;
   assign idle                             = &w_idle;

endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Scoreboard bench for the AXI4-Lite register slice: AW/W/B full, AR bypass, R half.
module tb_axi_lite_reg_slice;
   import axi_lite_reg_slice_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_awvalid, s_awready; logic [31:0] s_awaddr; logic [2:0] s_awprot;
   logic        s_wvalid, s_wready;   logic [31:0] s_wdata;  logic [3:0] s_wstrb;
   logic        s_bvalid, s_bready;   logic [1:0]  s_bresp;
   logic        s_arvalid, s_arready; logic [31:0] s_araddr; logic [2:0] s_arprot;
   logic        s_rvalid, s_rready;   logic [31:0] s_rdata;  logic [1:0] s_rresp;
   logic        m_awvalid, m_awready; logic [31:0] m_awaddr; logic [2:0] m_awprot;
   logic        m_wvalid, m_wready;   logic [31:0] m_wdata;  logic [3:0] m_wstrb;
   logic        m_bvalid, m_bready;   logic [1:0]  m_bresp;
   logic        m_arvalid, m_arready; logic [31:0] m_araddr; logic [2:0] m_arprot;
   logic        m_rvalid, m_rready;   logic [31:0] m_rdata;  logic [1:0] m_rresp;
   logic        idle;

   int checks = 0;
   int errors = 0;

   logic [34:0] aw_q[$];
   logic [35:0] w_q[$];
   logic [33:0] r_q[$];

   always #5 clk = ~clk;

   axi_lite_reg_slice #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .AW_MODE(SLICE_FULL), .W_MODE(SLICE_FULL), .B_MODE(SLICE_FULL),
      .AR_MODE(SLICE_BYPASS), .R_MODE(SLICE_HALF)
   ) dut (
      .clk(clk), .rst(rst),
      .i_s_axi_awvalid(s_awvalid), .o_s_axi_awready(s_awready),
      .i_s_axi_awaddr(s_awaddr),   .i_s_axi_awprot(s_awprot),
      .i_s_axi_wvalid(s_wvalid),   .o_s_axi_wready(s_wready),
      .i_s_axi_wdata(s_wdata),     .i_s_axi_wstrb(s_wstrb),
      .o_s_axi_bvalid(s_bvalid),   .i_s_axi_bready(s_bready),
      .o_s_axi_bresp(s_bresp),
      .i_s_axi_arvalid(s_arvalid), .o_s_axi_arready(s_arready),
      .i_s_axi_araddr(s_araddr),   .i_s_axi_arprot(s_arprot),
      .o_s_axi_rvalid(s_rvalid),   .i_s_axi_rready(s_rready),
      .o_s_axi_rdata(s_rdata),     .o_s_axi_rresp(s_rresp),
      .o_m_axi_awvalid(m_awvalid), .i_m_axi_awready(m_awready),
      .o_m_axi_awaddr(m_awaddr),   .o_m_axi_awprot(m_awprot),
      .o_m_axi_wvalid(m_wvalid),   .i_m_axi_wready(m_wready),
      .o_m_axi_wdata(m_wdata),     .o_m_axi_wstrb(m_wstrb),
      .i_m_axi_bvalid(m_bvalid),   .o_m_axi_bready(m_bready),
      .i_m_axi_bresp(m_bresp),
      .o_m_axi_arvalid(m_arvalid), .i_m_axi_arready(m_arready),
      .o_m_axi_araddr(m_araddr),   .o_m_axi_arprot(m_arprot),
      .i_m_axi_rvalid(m_rvalid),   .o_m_axi_rready(m_rready),
      .i_m_axi_rdata(m_rdata),     .i_m_axi_rresp(m_rresp),
      .idle(idle)
   );

   task automatic test_reset();
      rst = 1'b1;
      s_awvalid = 1'b1; s_awaddr = 32'hDEAD_BEE0; s_awprot = 3'b111;
      repeat (2) @(negedge clk);
      checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL reset_m_awvalid got %b want 0", m_awvalid); end
      checks++; if (s_awready !== 1'b1) begin errors++; $display("FAIL reset_s_awready got %b want 1", s_awready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
      s_awvalid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL post_reset_m_awvalid got %b want 0", m_awvalid); end
      checks++; if (s_awready !== 1'b1) begin errors++; $display("FAIL post_reset_s_awready got %b want 1", s_awready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %b want 1", idle); end
   endtask

   task automatic test_full_throughput();
      int          nout;
      logic        exp_v;
      logic [34:0] exp;
      nout = 0;
      m_awready = 1'b1;
      for (int c = 0; c < 19; c++) begin
         @(posedge clk); #1;
         s_awvalid = (c < 16);
         s_awaddr  = 32'(c * 4);
         s_awprot  = 3'(c);
         @(negedge clk);
         if (s_awvalid && s_awready) aw_q.push_back({s_awaddr, s_awprot});
         exp_v = (c >= 1) && (c <= 16);
         checks++; if (m_awvalid !== exp_v) begin errors++; $display("FAIL thru_valid cycle %0d got %b want %b", c, m_awvalid, exp_v); end
         if (c < 16) begin
            checks++; if (s_awready !== 1'b1) begin errors++; $display("FAIL thru_awready cycle %0d got %b want 1", c, s_awready); end
         end
         if (m_awvalid && m_awready) begin
            nout++;
            checks++;
            if (aw_q.size() == 0) begin errors++; $display("FAIL thru_unexpected_beat addr %h", m_awaddr); end
            else begin
               exp = aw_q.pop_front();
               if ({m_awaddr, m_awprot} !== exp) begin
                  errors++; $display("FAIL thru_payload got %h want %h", {m_awaddr, m_awprot}, exp);
               end
            end
         end
      end
      checks++; if (nout != 16) begin errors++; $display("FAIL thru_beat_count got %0d want 16", nout); end
      checks++; if (aw_q.size() != 0) begin errors++; $display("FAIL thru_leftover got %0d want 0", aw_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [35:0] stim [3];
      logic [35:0] exp;
      int idx, nout;
      stim[0] = {32'hA5A5_A5A5, 4'hF};
      stim[1] = {32'h5A5A_5A5A, 4'h3};
      stim[2] = {32'h0F0F_0F0F, 4'h1};
      idx = 0; nout = 0;
      for (int c = 0; c < 13; c++) begin
         @(posedge clk); #1;
         m_wready = (c >= 6);
         s_wvalid = (idx < 3);
         if (idx < 3) {s_wdata, s_wstrb} = stim[idx];
         @(negedge clk);
         if (c >= 2 && c <= 5) begin
            checks++; if (s_wready !== 1'b0) begin errors++; $display("FAIL bp_wready cycle %0d got %b want 0", c, s_wready); end
            checks++; if (!m_wvalid || {m_wdata, m_wstrb} !== stim[0]) begin
               errors++; $display("FAIL bp_stable cycle %0d got v=%b %h want v=1 %h", c, m_wvalid, {m_wdata, m_wstrb}, stim[0]);
            end
         end
         if (s_wvalid && s_wready) begin w_q.push_back(stim[idx]); idx++; end
         if (m_wvalid && m_wready) begin
            nout++;
            checks++;
            if (w_q.size() == 0) begin errors++; $display("FAIL bp_unexpected_beat data %h", m_wdata); end
            else begin
               exp = w_q.pop_front();
               if ({m_wdata, m_wstrb} !== exp) begin
                  errors++; $display("FAIL bp_payload got %h want %h", {m_wdata, m_wstrb}, exp);
               end
            end
         end
      end
      s_wvalid = 1'b0;
      checks++; if (nout != 3) begin errors++; $display("FAIL bp_beat_count got %0d want 3", nout); end
   endtask

   task automatic test_half();
      logic [33:0] stim [3];
      logic [33:0] exp;
      int idx, nout;
      stim[0] = {32'h1, RESP_OKAY};
      stim[1] = {32'h2, RESP_SLVERR};
      stim[2] = {32'h3, RESP_OKAY};
      idx = 0; nout = 0;
      s_rready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         m_rvalid = (idx < 3);
         if (idx < 3) {m_rdata, m_rresp} = stim[idx];
         @(negedge clk);
         if (m_rvalid && m_rready) begin r_q.push_back(stim[idx]); idx++; end
         if (s_rvalid && s_rready) begin
            checks++; if (c != 1 + 2 * nout) begin errors++; $display("FAIL half_rate beat %0d cycle got %0d want %0d", nout, c, 1 + 2 * nout); end
            nout++;
            checks++;
            if (r_q.size() == 0) begin errors++; $display("FAIL half_unexpected_beat data %h", s_rdata); end
            else begin
               exp = r_q.pop_front();
               if ({s_rdata, s_rresp} !== exp) begin
                  errors++; $display("FAIL half_payload got %h want %h", {s_rdata, s_rresp}, exp);
               end
            end
         end
      end
      m_rvalid = 1'b0;
      checks++; if (nout != 3) begin errors++; $display("FAIL half_beat_count got %0d want 3", nout); end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      m_arready = 1'b0;
      s_arvalid = 1'b1; s_araddr = 32'h0000_1000; s_arprot = 3'b010;
      #1;
      checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL byp_valid got %b want 1", m_arvalid); end
      checks++; if ({m_araddr, m_arprot} !== {32'h0000_1000, 3'b010}) begin
         errors++; $display("FAIL byp_payload got %h/%b want 00001000/010", m_araddr, m_arprot);
      end
      checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL byp_ready_low got %b want 0", s_arready); end
      m_arready = 1'b1;
      #1;
      checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL byp_ready_high got %b want 1", s_arready); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL byp_idle got %b want 1", idle); end
      @(posedge clk); #1 s_arvalid = 1'b0;
   endtask

   task automatic test_midflight_reset();
      s_bready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         m_bvalid = 1'b1;
         m_bresp  = (c == 0) ? RESP_OKAY : RESP_DECERR;
         @(negedge clk);
         checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL mr_accept beat %0d got %b want 1", c, m_bready); end
      end
      @(posedge clk); #1 m_bvalid = 1'b0;
      @(negedge clk);
      checks++; if (s_bvalid !== 1'b1 || s_bresp !== RESP_OKAY) begin
         errors++; $display("FAIL mr_head got v=%b resp=%b want v=1 resp=00", s_bvalid, s_bresp);
      end
      checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL mr_skid_full got %b want 0", m_bready); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mr_busy_idle got %b want 0", idle); end
      #1 rst = 1'b1;
      #1;
      checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL mr_async_drop got %b want 0", s_bvalid); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mr_idle got %b want 1", idle); end
      checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL mr_bready got %b want 1", m_bready); end
      @(posedge clk); #1 rst = 1'b0;
      s_bready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (s_bvalid !== 1'b0) begin errors++; $display("FAIL mr_stale cycle %0d got %b want 0", c, s_bvalid); end
      end
   endtask

   initial begin
      rst = 1'b1;
      s_awvalid = 0; s_awaddr = 0; s_awprot = 0;
      s_wvalid = 0;  s_wdata = 0;  s_wstrb = 0;
      s_bready = 1;
      s_arvalid = 0; s_araddr = 0; s_arprot = 0;
      s_rready = 1;
      m_awready = 1; m_wready = 1; m_arready = 1;
      m_bvalid = 0;  m_bresp = 0;
      m_rvalid = 0;  m_rdata = 0;  m_rresp = 0;
      test_reset();
      test_full_throughput();
      test_backpressure();
      test_half();
      test_bypass();
      test_midflight_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
